// File: rtl/mips_fetch_ifetch.sv
// rtl/mips_fetch_ifetch.sv - instruction fetch front end with in-order response queue (optional MIPS_FETCH_BYPASS_EN)
module mips_fetch_ifetch #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] pcAddr_i,
    input  logic              pcValid_i,
    output logic              pcReady_o,
    input  logic              redirect_i,
    output logic              memReqValid_o,
    input  logic              memReqReady_i,
    output logic [ADDR_W-1:0] memReqAddr_o,
    input  logic              memRspValid_i,
    input  logic [31:0]       memRspData_i,
    output logic              instValid_o,
    input  logic              instReady_i,
    output logic [31:0]       instruction_o,
    output logic [ADDR_W-1:0] instAddr_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // Stale responses can pile up across back-to-back redirects while memory is slow,
    // so the discard counter gets extra headroom beyond the occupancy range.
    localparam int DW = CW + 2;

    // Occupancy / in-flight / discard bookkeeping
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [DW-1:0] discard_q, discard_d;

    // Instruction queue (word + address) and in-flight address FIFO
    logic [PW-1:0]     q_rd_q, q_rd_d, q_wr_q, q_wr_d;
    logic [PW-1:0]     af_rd_q, af_rd_d, af_wr_q, af_wr_d;
    logic [31:0]       q_word_q [DEPTH];
    logic [ADDR_W-1:0] q_addr_q [DEPTH];
    logic [ADDR_W-1:0] af_addr_q[DEPTH];

    logic credit;
    logic fire;
    logic rsp_take;
    logic rsp_drop;
    logic q_pop;
    logic enq;
    logic byp_valid;
    logic byp_consume;

    // A new request may only be issued while every queue slot is either free or already promised
    assign credit = ({1'b0, occ_q} + {1'b0, inflight_q}) < (CW + 1)'(DEPTH);

    assign memReqValid_o = pcValid_i & credit & ~redirect_i & ~reset_i;
    assign pcReady_o     = memReqReady_i & credit & ~redirect_i & ~reset_i;
    assign memReqAddr_o  = pcAddr_i & ~ADDR_W'(3);
    assign fire          = memReqValid_o & memReqReady_i;

    // Responses for requests issued before a redirect are swallowed first
    assign rsp_drop = memRspValid_i & (discard_q != '0);
    assign rsp_take = memRspValid_i & (discard_q == '0) & (inflight_q != '0);
    assign q_pop    = (occ_q != '0) & instReady_i;

`ifdef MIPS_FETCH_BYPASS_EN
    assign byp_valid   = rsp_take & (occ_q == '0) & ~redirect_i & ~reset_i;
    assign byp_consume = byp_valid & instReady_i;
`else
    assign byp_valid   = 1'b0;
    assign byp_consume = 1'b0;
`endif

    assign enq = rsp_take & ~redirect_i & ~byp_consume;

    // Queue head drives decode; a live bypass word is shown only while the queue is empty
    always_comb begin
        instValid_o   = (occ_q != '0) | byp_valid;
        instruction_o = '0;
        instAddr_o    = '0;
        if (occ_q != '0) begin
            instruction_o = q_word_q[q_rd_q];
            instAddr_o    = q_addr_q[q_rd_q];
        end else if (byp_valid) begin
            instruction_o = memRspData_i;
            instAddr_o    = af_addr_q[af_rd_q];
        end
    end

    // Next-state for counters and pointers; redirect empties everything and converts in-flight to discard
    always_comb begin
        occ_d      = occ_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        q_rd_d     = q_rd_q;
        q_wr_d     = q_wr_q;
        af_rd_d    = af_rd_q;
        af_wr_d    = af_wr_q;
        if (redirect_i) begin
            occ_d      = '0;
            inflight_d = '0;
            q_rd_d     = '0;
            q_wr_d     = '0;
            af_rd_d    = '0;
            af_wr_d    = '0;
            discard_d  = discard_q + DW'(inflight_q) - DW'(rsp_drop | rsp_take);
        end else begin
            occ_d      = occ_q + CW'(enq) - CW'(q_pop);
            inflight_d = inflight_q + CW'(fire) - CW'(rsp_take);
            discard_d  = discard_q - DW'(rsp_drop);
            if (q_pop) begin
                q_rd_d = q_rd_q + PW'(1);
            end
            if (enq) begin
                q_wr_d = q_wr_q + PW'(1);
            end
            if (fire) begin
                af_wr_d = af_wr_q + PW'(1);
            end
            if (rsp_take) begin
                af_rd_d = af_rd_q + PW'(1);
            end
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            occ_q      <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            q_rd_q     <= '0;
            q_wr_q     <= '0;
            af_rd_q    <= '0;
            af_wr_q    <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            q_rd_q     <= q_rd_d;
            q_wr_q     <= q_wr_d;
            af_rd_q    <= af_rd_d;
            af_wr_q    <= af_wr_d;
        end
    end

    // Storage arrays; contents are only observed through valid pointers, so no reset needed
    always_ff @(posedge clock_i) begin
        if (!reset_i && enq) begin
            q_word_q[q_wr_q] <= memRspData_i;
            q_addr_q[q_wr_q] <= af_addr_q[af_rd_q];
        end
        if (fire) begin
            af_addr_q[af_wr_q] <= memReqAddr_o;
        end
    end

    // A response with nothing outstanding means the memory broke the protocol
    assert property (@(posedge clock_i) disable iff (reset_i)
        memRspValid_i |-> ((inflight_q != '0) || (discard_q != '0)));

endmodule
